// File: rtl/seven_segment_reader.sv
// Seven-segment bus reader: synchronizes, debounces and decodes a segment pattern to hex.
// Define SEVEN_SEGMENT_READER_COUNT_EN to include the 8-bit valid-update counter.
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] seg_in,
  input  logic       count_clr,
  output logic [3:0] digit,
  output logic       valid,
  output logic       error,
  output logic       dp,
  output logic       change,
  output logic [7:0] count
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [7:0] s1, s2, cand, acc, cnt;
  logic       accept;
  logic [3:0] dec_digit;
  logic       dec_valid, dec_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
    end else if (ena) begin
      s1 <= seg_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Decoding cand rather than acc lets the outputs load in the same edge as acc.
  assign accept = (cnt == CNT_MAX) && (s2 == cand) && (cand != acc);

  always_comb begin
    dec_digit = '0;
    dec_valid = 1'b1;
    dec_error = 1'b0;
    case (cand[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      7'h00: dec_valid = 1'b0;
      default: begin
        dec_valid = 1'b0;
        dec_error = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      digit  <= '0;
      valid  <= 1'b0;
      error  <= 1'b0;
      dp     <= 1'b0;
      change <= 1'b0;
    end else if (!ena) begin
      change <= 1'b0;
    end else begin
      change <= accept;
      if (accept) begin
        acc   <= cand;
        digit <= dec_digit;
        valid <= dec_valid;
        error <= dec_error;
        dp    <= cand[7];
      end
    end
  end

`ifdef SEVEN_SEGMENT_READER_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (count_clr) begin
        count <= '0;
      end else if (accept && dec_valid) begin
        count <= count + 8'd1;
      end
    end
  end
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign count = '0;
`endif

endmodule
